br_tag_alloc_ctrl: RTL and testbench

//  Sequencer for the branch status buffer: allocates in-order tags to decode, retires tags at commit.

---
 rtl/br_tag_alloc_if.sv | 33 +++
 rtl/br_tag_alloc_ctrl.sv | 141 ++++++++++++++
 tb/tb_br_tag_alloc_ctrl.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/br_tag_alloc_if.sv
// Branch-tag controller interface: bundles the decode, commit, writeback and
// buffer strobes between the environment (master) and the controller (slave).
interface br_tag_alloc_if #(
    parameter int ADDR = 3
);
    logic            alloc_req_;
    logic            alloc_grant_;
    logic [ADDR-1:0] alloc_tag;
    logic            commit_req_;
    logic            mispred_;
    logic [ADDR-1:0] mispred_idx;
    logic            buf_we_;
    logic            buf_re_;
    logic            buf_wb_flush_;
    logic [ADDR-1:0] buf_wb_idx;
    logic            buf_busy;
    logic            fe_stall;
    logic [ADDR:0]   count;

    // Decode/commit/writeback/buffer side.
    modport master (
        output alloc_req_, commit_req_, mispred_, mispred_idx, buf_busy,
        input  alloc_grant_, alloc_tag, buf_we_, buf_re_, buf_wb_flush_,
               buf_wb_idx, fe_stall, count
    );

    // Controller side.
    modport slave (
        input  alloc_req_, commit_req_, mispred_, mispred_idx, buf_busy,
        output alloc_grant_, alloc_tag, buf_we_, buf_re_, buf_wb_flush_,
               buf_wb_idx, fe_stall, count
    );
endinterface

// File: rtl/br_tag_alloc_ctrl.sv
// Branch status buffer sequencer: hands out in-order tags to decode, retires
// them at commit, flushes younger tags on a mispredict and stalls the frontend
// for RECOVER_CYC cycles afterwards.
// Optional macro BR_CTRL_PERF_EN adds saturating flush/stall event counters.
`ifndef PredMaxDepth
`define PredMaxDepth 8
`endif

module br_tag_alloc_ctrl #(
    parameter int DEPTH       = `PredMaxDepth,
    parameter int ADDR        = $clog2(DEPTH),
    parameter int RECOVER_CYC = 2
) (
    input  logic        clk,
    input  logic        reset_,
    br_tag_alloc_if.slave bif
`ifdef BR_CTRL_PERF_EN
    ,
    output logic [31:0] perf_flush_cnt,
    output logic [31:0] perf_stall_cnt
`endif
);

    typedef enum logic [0:0] {
        ST_RUN     = 1'b0,
        ST_RECOVER = 1'b1
    } state_e;

    localparam logic [ADDR:0] FULL     = (ADDR + 1)'(DEPTH);
    localparam logic [3:0]    REC_LAST = 4'(RECOVER_CYC);

    state_e          state_q, state_d;
    logic [3:0]      rcnt_q, rcnt_d;
    logic [ADDR-1:0] head_q, head_d;
    logic [ADDR-1:0] tail_q, tail_d;
    logic [ADDR:0]   count_q, count_d;

    logic [ADDR-1:0] offset;
    logic            in_range;
    logic            flush;
    logic            commit;
    logic            grant;
    logic            stall;

    // Decode this cycle's events; every strobe is masked while reset is held
    // so the outputs sit at their idle values during reset.
    always_comb begin
        // Distance from the oldest live tag; the mispredicted tag is live iff
        // that distance is below the occupancy (wraps naturally mod DEPTH).
        offset   = bif.mispred_idx - tail_q;
        in_range = ({1'b0, offset} < count_q);
        flush    = reset_ && !bif.mispred_ && in_range;
        commit   = reset_ && !bif.commit_req_ && (count_q != '0);
        // Any mispredict report, even an ignored one, holds off the grant.
        grant    = reset_ && !bif.alloc_req_ && (state_q == ST_RUN) &&
                   bif.mispred_ && (count_q != FULL) && !bif.buf_busy;
        stall    = reset_ && ((state_q == ST_RECOVER) ||
                              (count_q == FULL) || bif.buf_busy);
    end

    // Next-state logic for the FSM, the recovery counter and the pointers.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d = state_q;
        rcnt_d  = rcnt_q;
        head_d  = head_q;
        tail_d  = tail_q + ADDR'(commit);
        count_d = count_q;

        if (flush) begin
            // Everything younger than the mispredicted tag is discarded.
            head_d  = bif.mispred_idx + ADDR'(1);
            count_d = {1'b0, offset} + (ADDR + 1)'(1) - (ADDR + 1)'(commit);
            state_d = ST_RECOVER;
            rcnt_d  = '0;
        end else begin
            head_d  = head_q + ADDR'(grant);
            count_d = count_q + (ADDR + 1)'(grant) - (ADDR + 1)'(commit);
            if (state_q == ST_RECOVER) begin
                if (rcnt_q + 4'd1 == REC_LAST) begin
                    state_d = ST_RUN;
                    rcnt_d  = '0;
                end else begin
                    rcnt_d  = rcnt_q + 4'd1;
                end
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of statement order.
        if (!reset_) begin
            state_q <= ST_RUN;
            rcnt_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            rcnt_q  <= rcnt_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Drive the interface outputs (active-low strobes are inverted events).
    always_comb begin
        bif.alloc_grant_  = !grant;
        bif.buf_we_       = !grant;
        bif.alloc_tag     = reset_ ? head_q : '0;
        bif.buf_re_       = !commit;
        bif.buf_wb_flush_ = !flush;
        bif.buf_wb_idx    = flush ? bif.mispred_idx : '0;
        bif.fe_stall      = stall;
        bif.count         = count_q;
    end

`ifdef BR_CTRL_PERF_EN
    logic [31:0] perf_flush_q;
    logic [31:0] perf_stall_q;

    // Saturating event counters for accepted mispredicts and stall cycles.
    always_ff @(posedge clk) begin
        if (!reset_) begin
            perf_flush_q <= '0;
            perf_stall_q <= '0;
        end else begin
            if (flush && !(&perf_flush_q)) perf_flush_q <= perf_flush_q + 32'd1;
            if (stall && !(&perf_stall_q)) perf_stall_q <= perf_stall_q + 32'd1;
        end
    end

    assign perf_flush_cnt = perf_flush_q;
    assign perf_stall_cnt = perf_stall_q;
`endif

endmodule

// File: tb/tb_br_tag_alloc_ctrl.sv
// Directed bench for br_tag_alloc_ctrl with DEPTH=8, RECOVER_CYC=2.
module tb_br_tag_alloc_ctrl;

    logic clk;
    logic reset_;
    int   total;
    int   passed;

    br_tag_alloc_if #(.ADDR(3)) bif ();

`ifdef BR_CTRL_PERF_EN
    logic [31:0] perf_flush_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    br_tag_alloc_ctrl #(
        .DEPTH       (8),
        .RECOVER_CYC (2)
    ) dut (
        .clk    (clk),
        .reset_ (reset_),
        .bif    (bif.slave)
`ifdef BR_CTRL_PERF_EN
        ,
        .perf_flush_cnt (perf_flush_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    initial begin
        total  = 0;
        passed = 0;
        reset_ = 1'b0;
        bif.alloc_req_  = 1'b1;
        bif.commit_req_ = 1'b1;
        bif.mispred_    = 1'b1;
        bif.mispred_idx = '0;
        bif.buf_busy    = 1'b0;

        // Reset values
        tick(); tick(); #2;
        check("rst_count",  32'(bif.count), 0);
        check("rst_grant",  32'(bif.alloc_grant_), 1);
        check("rst_we",     32'(bif.buf_we_), 1);
        check("rst_re",     32'(bif.buf_re_), 1);
        check("rst_flush",  32'(bif.buf_wb_flush_), 1);
        check("rst_tag",    32'(bif.alloc_tag), 0);
        check("rst_wbidx",  32'(bif.buf_wb_idx), 0);
        check("rst_stall",  32'(bif.fe_stall), 0);
        reset_ = 1'b1;

        // 1. Fill: tags 0..7, then the ninth request is refused
        bif.alloc_req_ = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #2;
            check("fill_grant", 32'(bif.alloc_grant_), 0);
            check("fill_we",    32'(bif.buf_we_), 0);
            check("fill_tag",   32'(bif.alloc_tag), 32'(i));
            tick();
        end
        #2;
        check("full_count", 32'(bif.count), 8);
        check("full_grant", 32'(bif.alloc_grant_), 1);
        check("full_stall", 32'(bif.fe_stall), 1);

        // 2. Full with simultaneous request and commit: commit only
        bif.commit_req_ = 1'b0;
        #2;
        check("fc_re",    32'(bif.buf_re_), 0);
        check("fc_grant", 32'(bif.alloc_grant_), 1);
        tick();
        bif.commit_req_ = 1'b1;
        #2;
        check("fc_count7", 32'(bif.count), 7);
        check("fc_grant2", 32'(bif.alloc_grant_), 0);
        check("fc_tag0",   32'(bif.alloc_tag), 0);
        tick();
        bif.alloc_req_ = 1'b1;
        #2;
        check("fc_count8", 32'(bif.count), 8);

        // 3. Build head=5, tail=1 (empty commit dropped on the way)
        reset_ = 1'b0;
        tick();
        reset_ = 1'b1;
        bif.alloc_req_  = 1'b0;
        bif.commit_req_ = 1'b0;
        #2;
        check("empty_re",    32'(bif.buf_re_), 1);
        check("empty_grant", 32'(bif.alloc_grant_), 0);
        tick();
        bif.commit_req_ = 1'b1;
        repeat (4) tick();
        bif.alloc_req_  = 1'b1;
        bif.commit_req_ = 1'b0;
        #2;
        check("c1_re", 32'(bif.buf_re_), 0);
        tick();
        bif.commit_req_ = 1'b1;
        #2;
        check("c1_count", 32'(bif.count), 4);
        check("c1_tag",   32'(bif.alloc_tag), 5);

        // Mispredict tag 2 with a same-cycle request
        bif.mispred_    = 1'b0;
        bif.mispred_idx = 3'd2;
        bif.alloc_req_  = 1'b0;
        #2;
        check("mp_flush", 32'(bif.buf_wb_flush_), 0);
        check("mp_idx",   32'(bif.buf_wb_idx), 2);
        check("mp_grant", 32'(bif.alloc_grant_), 1);
        tick();
        bif.mispred_ = 1'b1;
        #2;
        check("rec1_count", 32'(bif.count), 2);
        check("rec1_tag",   32'(bif.alloc_tag), 3);
        check("rec1_stall", 32'(bif.fe_stall), 1);
        check("rec1_grant", 32'(bif.alloc_grant_), 1);
        tick(); #2;
        check("rec2_stall", 32'(bif.fe_stall), 1);
        check("rec2_grant", 32'(bif.alloc_grant_), 1);
        tick(); #2;
        check("rec3_stall", 32'(bif.fe_stall), 0);
        check("rec3_grant", 32'(bif.alloc_grant_), 0);
        check("rec3_tag",   32'(bif.alloc_tag), 3);
        tick();
        bif.alloc_req_ = 1'b1;

        // 5. Out-of-range mispredict (tail=1, head=4): ignored
        bif.mispred_    = 1'b0;
        bif.mispred_idx = 3'd4;
        #2;
        check("oor_flush", 32'(bif.buf_wb_flush_), 1);
        check("oor_idx",   32'(bif.buf_wb_idx), 0);
        tick();
        bif.mispred_ = 1'b1;
        #2;
        check("oor_count", 32'(bif.count), 3);
        check("oor_tag",   32'(bif.alloc_tag), 4);
        check("oor_stall", 32'(bif.fe_stall), 0);

        // 4. Walk to tail=6, head=2 via simultaneous grant+commit
        bif.alloc_req_  = 1'b0;
        bif.commit_req_ = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #2;
            check("gc_grant", 32'(bif.alloc_grant_), 0);
            check("gc_re",    32'(bif.buf_re_), 0);
            check("gc_tag",   32'(bif.alloc_tag), 32'((4 + i) % 8));
            tick();
        end
        bif.commit_req_ = 1'b1;
        #2;
        check("gc_count3", 32'(bif.count), 3);
        tick();
        bif.alloc_req_ = 1'b1;
        #2;
        check("w_count4", 32'(bif.count), 4);
        check("w_tag2",   32'(bif.alloc_tag), 2);

        // Wrap mispredict of tag 0 with a same-cycle commit
        bif.mispred_    = 1'b0;
        bif.mispred_idx = 3'd0;
        bif.commit_req_ = 1'b0;
        #2;
        check("wmp_flush", 32'(bif.buf_wb_flush_), 0);
        check("wmp_re",    32'(bif.buf_re_), 0);
        tick();
        bif.mispred_    = 1'b1;
        bif.commit_req_ = 1'b1;
        #2;
        check("wmp_count", 32'(bif.count), 2);
        check("wmp_tag",   32'(bif.alloc_tag), 1);
        check("wmp_stall", 32'(bif.fe_stall), 1);

        // 6. Second mispredict in RECOVER (tag 7 = tail) reloads the counter
        bif.mispred_    = 1'b0;
        bif.mispred_idx = 3'd7;
        #2;
        check("mp2_flush", 32'(bif.buf_wb_flush_), 0);
        check("mp2_idx",   32'(bif.buf_wb_idx), 7);
        tick();
        bif.mispred_   = 1'b1;
        bif.alloc_req_ = 1'b0;
        #2;
        check("mp2_count",  32'(bif.count), 1);
        check("mp2_tag",    32'(bif.alloc_tag), 0);
        check("mp2_stall1", 32'(bif.fe_stall), 1);
        tick(); #2;
        check("mp2_stall2", 32'(bif.fe_stall), 1);
        check("mp2_grant2", 32'(bif.alloc_grant_), 1);
        tick(); #2;
        check("mp2_stall3", 32'(bif.fe_stall), 0);
        check("mp2_grant3", 32'(bif.alloc_grant_), 0);
        tick();
        bif.alloc_req_ = 1'b1;

        // Reset in the middle of recovery
        bif.mispred_    = 1'b0;
        bif.mispred_idx = 3'd0;
        #2;
        check("mp3_flush", 32'(bif.buf_wb_flush_), 0);
        tick();
        bif.mispred_ = 1'b1;
        #2;
        check("mp3_stall", 32'(bif.fe_stall), 1);
        reset_ = 1'b0;
        tick();
        reset_ = 1'b1;
        #2;
        check("rr_stall", 32'(bif.fe_stall), 0);
        check("rr_count", 32'(bif.count), 0);
        check("rr_tag",   32'(bif.alloc_tag), 0);
        check("rr_flush", 32'(bif.buf_wb_flush_), 1);
        check("rr_re",    32'(bif.buf_re_), 1);
        check("rr_grant", 32'(bif.alloc_grant_), 1);
        bif.alloc_req_ = 1'b0;
        #2;
        check("rr_grant2", 32'(bif.alloc_grant_), 0);

        // Buffer busy blocks grant and stalls
        bif.buf_busy = 1'b1;
        #1;
        check("busy_grant", 32'(bif.alloc_grant_), 1);
        check("busy_stall", 32'(bif.fe_stall), 1);
        tick();
        bif.buf_busy   = 1'b0;
        bif.alloc_req_ = 1'b1;
        #2;
        check("busy_count", 32'(bif.count), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
